tue_apb_regs: RTL and testbench

APB3 completer that implements the TUE register file at the fixed offsets 0x000–0x0A4. It accumulates a table-update request from CPU writes (op, stage, table_id, 512b key/mask, action) and launches one tue_req_t to the TUE engine on COMMIT. It then reports busy/done/error in STATUS. It is the responder end of the CPU→TUE programming path, sitting between the control-CPU APB bridge and the TUE.

---
 rtl/tue_apb_regs.sv | 223 ++++++++++++++++++++++
 tb/tb_tue_apb_regs.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tue_apb_regs.sv
// TUE register file: APB3 completer that stages a table-update request
// from CPU writes and hands one tue_req_t to the TUE engine on COMMIT.
package tue_pkg;
  localparam int unsigned MAU_TCAM_KEY_W = 512;

  typedef enum logic [1:0] {
    TUE_INSERT = 2'd0,
    TUE_DELETE = 2'd1,
    TUE_MODIFY = 2'd2,
    TUE_FLUSH  = 2'd3
  } tue_op_t;

  typedef struct packed {
    tue_op_t                   op;
    logic [4:0]                stage;
    logic [15:0]               table_id;
    logic [MAU_TCAM_KEY_W-1:0] key;
    logic [MAU_TCAM_KEY_W-1:0] mask;
    logic [15:0]               action_id;
    logic [111:0]              params;
  } tue_req_t;
endpackage

module tue_apb_regs
  import tue_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned KEY_W  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              req_valid,
  input  logic              req_ready,
  output tue_req_t          req,
  input  logic              tue_done,
  input  logic              tue_err
);

  localparam int unsigned KEY_WORDS = KEY_W / 32;
  localparam int unsigned WORD_W    = ADDR_W - 2;
  localparam int unsigned KEY_BASE  = 32'h010 >> 2;
  localparam int unsigned MASK_BASE = 32'h050 >> 2;

  localparam logic [WORD_W-1:0] W_CMD    = WORD_W'(32'h000 >> 2);
  localparam logic [WORD_W-1:0] W_TID    = WORD_W'(32'h004 >> 2);
  localparam logic [WORD_W-1:0] W_STAGE  = WORD_W'(32'h008 >> 2);
  localparam logic [WORD_W-1:0] W_ACTION = WORD_W'(32'h090 >> 2);
  localparam logic [WORD_W-1:0] W_P0     = WORD_W'(32'h094 >> 2);
  localparam logic [WORD_W-1:0] W_P1     = WORD_W'(32'h098 >> 2);
  localparam logic [WORD_W-1:0] W_P2     = WORD_W'(32'h09C >> 2);
  localparam logic [WORD_W-1:0] W_STATUS = WORD_W'(32'h0A0 >> 2);
  localparam logic [WORD_W-1:0] W_COMMIT = WORD_W'(32'h0A4 >> 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]           state;
  tue_op_t              op_q;
  logic [15:0]          table_id_q;
  logic [4:0]           stage_q;
  logic [KEY_W-1:0]     key_q;
  logic [KEY_W-1:0]     mask_q;
  logic [15:0]          action_id_q;
  logic [111:0]         params_q;
  logic                 done_q;
  logic                 err_q;
  logic                 cmd_err_q;

  logic [WORD_W-1:0]    word;
  logic [KEY_WORDS-1:0] key_sel;
  logic [KEY_WORDS-1:0] mask_sel;
  logic                 hit_cmd, hit_tid, hit_stage, hit_action;
  logic                 hit_p0, hit_p1, hit_p2, hit_status, hit_commit;
  logic                 hit_shadow, mapped;
  logic                 busy, access, err_resp, wr_ok;
  logic [31:0]          rdata;
  tue_req_t             snap;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^paddr[1:0];
  assign pready          = 1'b1;

  // Address decode
  always_comb begin
    word       = paddr[ADDR_W-1:2];
    hit_cmd    = (word == W_CMD);
    hit_tid    = (word == W_TID);
    hit_stage  = (word == W_STAGE);
    hit_action = (word == W_ACTION);
    hit_p0     = (word == W_P0);
    hit_p1     = (word == W_P1);
    hit_p2     = (word == W_P2);
    hit_status = (word == W_STATUS);
    hit_commit = (word == W_COMMIT);
    key_sel    = '0;
    mask_sel   = '0;
    for (int unsigned i = 0; i < KEY_WORDS; i++) begin
      key_sel[i]  = (word == WORD_W'(KEY_BASE + i));
      mask_sel[i] = (word == WORD_W'(MASK_BASE + i));
    end
    hit_shadow = hit_cmd | hit_tid | hit_stage | hit_action | hit_p0 | hit_p1 |
                 hit_p2 | (|key_sel) | (|mask_sel);
    mapped     = hit_shadow | hit_status | hit_commit;
  end

  assign busy   = (state != S_IDLE);
  assign access = psel & penable;

  // Writes to the engine-facing registers are refused while a request is in flight
  always_comb begin
    err_resp = ~mapped
             | (pwrite & hit_status)
             | (pwrite & busy & (hit_shadow | hit_commit));
    wr_ok    = access & pwrite & ~err_resp;
  end

  always_comb begin
    rdata = '0;
    if (hit_cmd)    rdata[1:0]  = op_q;
    if (hit_tid)    rdata[15:0] = table_id_q;
    if (hit_stage)  rdata[4:0]  = stage_q;
    if (hit_action) rdata       = {params_q[111:96], action_id_q};
    if (hit_p0)     rdata       = params_q[31:0];
    if (hit_p1)     rdata       = params_q[63:32];
    if (hit_p2)     rdata       = params_q[95:64];
    if (hit_status) rdata[3:0]  = {cmd_err_q, err_q, done_q, busy};
    for (int unsigned i = 0; i < KEY_WORDS; i++) begin
      if (key_sel[i])  rdata = key_q[32*i +: 32];
      if (mask_sel[i]) rdata = mask_q[32*i +: 32];
    end
  end

  assign prdata  = access ? rdata : '0;
  assign pslverr = access & err_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= TUE_INSERT;
      table_id_q  <= '0;
      stage_q     <= '0;
      key_q       <= '0;
      mask_q      <= '0;
      action_id_q <= '0;
      params_q    <= '0;
    end else if (wr_ok) begin
      if (hit_cmd)   op_q       <= tue_op_t'(pwdata[1:0]);
      if (hit_tid)   table_id_q <= pwdata[15:0];
      if (hit_stage) stage_q    <= pwdata[4:0];
      if (hit_action) begin
        action_id_q       <= pwdata[15:0];
        params_q[111:96]  <= pwdata[31:16];
      end
      if (hit_p0) params_q[31:0]  <= pwdata;
      if (hit_p1) params_q[63:32] <= pwdata;
      if (hit_p2) params_q[95:64] <= pwdata;
      for (int unsigned i = 0; i < KEY_WORDS; i++) begin
        if (key_sel[i])  key_q[32*i +: 32]  <= pwdata;
        if (mask_sel[i]) mask_q[32*i +: 32] <= pwdata;
      end
    end
  end

  always_comb begin
    snap           = '0;
    snap.op        = op_q;
    snap.stage     = stage_q;
    snap.table_id  = table_id_q;
    snap.key       = key_q;
    snap.mask      = mask_q;
    snap.action_id = action_id_q;
    snap.params    = params_q;
  end

  // tue_done is only honoured in WAIT, so a done coincident with accept is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_valid <= 1'b0;
      req       <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_ok && hit_commit && pwdata[0]) begin
            req       <= snap;
            req_valid <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cmd_err_q <= 1'b0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tue_done) begin
            done_q <= 1'b1;
            err_q  <= tue_err;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (access && pwrite && hit_commit && busy) cmd_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tue_apb_regs.sv
// Scoreboard bench for tue_apb_regs: APB expectations are queued when an
// access is launched and compared when the access phase presents its response.
module tb_tue_apb_regs;
  import tue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        req_valid;
  logic        req_ready = 1'b0;
  tue_req_t    req;
  logic        tue_done = 1'b0;
  logic        tue_err = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];
  tue_req_t    exp_req;

  tue_apb_regs #(.ADDR_W(12), .KEY_W(512)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .req_valid(req_valid), .req_ready(req_ready), .req(req),
    .tue_done(tue_done), .tue_err(tue_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
    else chk(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  task automatic apb_write(input string tag, input logic [11:0] a, input logic [31:0] d,
                           input logic exp_err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    sb_push({tag, "_slverr"}, 32'(exp_err));
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    sb_pop(32'(pslverr));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input string tag, input logic [11:0] a, input logic [31:0] exp_d,
                          input logic exp_err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    sb_push({tag, "_data"}, exp_d);
    sb_push({tag, "_slverr"}, 32'(exp_err));
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    sb_pop(prdata);
    sb_pop(32'(pslverr));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_req(input string tag);
    chk({tag, "_op"},     32'(req.op),              32'(exp_req.op));
    chk({tag, "_stage"},  32'(req.stage),           32'(exp_req.stage));
    chk({tag, "_tid"},    32'(req.table_id),        32'(exp_req.table_id));
    chk({tag, "_key0"},   req.key[31:0],            exp_req.key[31:0]);
    chk({tag, "_key511"}, 32'(req.key[511]),        32'(exp_req.key[511]));
    chk({tag, "_act"},    32'(req.action_id),       32'(exp_req.action_id));
    chk({tag, "_phi"},    32'(req.params[111:96]),  32'(exp_req.params[111:96]));
    chk({tag, "_p0"},     req.params[31:0],         exp_req.params[31:0]);
    chk({tag, "_all"},    32'(req == exp_req),      32'd1);
  endtask

  task automatic accept(input logic with_done);
    @(posedge clk); #1;
    req_ready = 1'b1; tue_done = with_done;
    @(posedge clk); #1;
    req_ready = 1'b0; tue_done = 1'b0;
    chk("accept_valid_drop", 32'(req_valid), 32'd0);
  endtask

  task automatic pulse_done(input logic e);
    @(posedge clk); #1;
    tue_done = 1'b1; tue_err = e;
    @(posedge clk); #1;
    tue_done = 1'b0; tue_err = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("pready", 32'(pready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    apb_read("rst_status", 12'h0A0, 32'h0, 1'b0);
    apb_read("rst_key0", 12'h010, 32'h0, 1'b0);

    // Full insert
    apb_write("w_cmd", 12'h000, 32'h0, 1'b0);
    apb_write("w_stage", 12'h008, 32'd5, 1'b0);
    apb_write("w_tid", 12'h004, 32'h0123, 1'b0);
    apb_write("w_key0", 12'h010, 32'hDEADBEEF, 1'b0);
    apb_write("w_key15", 12'h04C, 32'h80000000, 1'b0);
    apb_write("w_mask0", 12'h050, 32'hFFFFFFFF, 1'b0);
    apb_write("w_action", 12'h090, 32'hABCD0042, 1'b0);
    apb_write("w_p0", 12'h094, 32'h11111111, 1'b0);
    exp_req = '0;
    exp_req.op = TUE_INSERT;
    exp_req.stage = 5'd5;
    exp_req.table_id = 16'h0123;
    exp_req.key[31:0] = 32'hDEADBEEF;
    exp_req.key[511:480] = 32'h80000000;
    exp_req.mask[31:0] = 32'hFFFFFFFF;
    exp_req.action_id = 16'h0042;
    exp_req.params[111:96] = 16'hABCD;
    exp_req.params[31:0] = 32'h11111111;

    apb_write("commit0", 12'h0A4, 32'h0, 1'b0);
    chk("commit0_no_valid", 32'(req_valid), 32'd0);
    apb_read("commit0_status", 12'h0A0, 32'h0, 1'b0);
    apb_write("commit1", 12'h0A4, 32'h1, 1'b0);
    chk("commit1_valid", 32'(req_valid), 32'd1);
    check_req("req1");

    // Backpressure
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(req_valid), 32'd1);
      chk("bp_req_stable", 32'(req == exp_req), 32'd1);
    end
    apb_read("bp_status", 12'h0A0, 32'h1, 1'b0);
    accept(1'b0);
    @(posedge clk);
    pulse_done(1'b0);
    apb_read("done_status", 12'h0A0, 32'h2, 1'b0);

    // Idle-state boundaries
    pulse_done(1'b1);
    apb_read("idle_done_ignored", 12'h0A0, 32'h2, 1'b0);
    apb_read("commit_reads0", 12'h0A4, 32'h0, 1'b0);
    apb_read("r_key15", 12'h04C, 32'h80000000, 1'b0);
    apb_read("r_action", 12'h090, 32'hABCD0042, 1'b0);
    apb_read("r_hole_0c", 12'h00C, 32'h0, 1'b1);

    // Busy rejection
    apb_write("commit2", 12'h0A4, 32'h1, 1'b0);
    check_req("req2");
    apb_write("busy_w_key0", 12'h010, 32'h5, 1'b1);
    apb_read("busy_r_key0", 12'h010, 32'hDEADBEEF, 1'b0);
    apb_write("busy_commit", 12'h0A4, 32'h1, 1'b1);
    apb_read("busy_status", 12'h0A0, 32'h9, 1'b0);
    pulse_done(1'b1);
    apb_read("req_done_ignored", 12'h0A0, 32'h9, 1'b0);
    accept(1'b1);
    apb_read("wait_status", 12'h0A0, 32'h9, 1'b0);
    pulse_done(1'b0);
    apb_read("done_cmderr_status", 12'h0A0, 32'hA, 1'b0);
    apb_write("commit3", 12'h0A4, 32'h1, 1'b0);
    apb_read("commit3_status", 12'h0A0, 32'h1, 1'b0);

    // Error path
    accept(1'b0);
    @(posedge clk);
    pulse_done(1'b1);
    apb_read("err_status", 12'h0A0, 32'h6, 1'b0);
    apb_write("w_status", 12'h0A0, 32'hF, 1'b1);
    apb_read("r_unmapped_b0", 12'h0B0, 32'h0, 1'b1);
    apb_write("w_stage_ff", 12'h008, 32'hFFFFFFFF, 1'b0);
    apb_read("r_stage_ff", 12'h008, 32'h1F, 1'b0);
    apb_write("w_tid_ff", 12'h004, 32'hFFFFFFFF, 1'b0);
    apb_read("r_tid_ff", 12'h004, 32'hFFFF, 1'b0);

    // Reset while request pending
    apb_write("w_cmd2", 12'h000, 32'h2, 1'b0);
    apb_read("r_cmd2", 12'h000, 32'h2, 1'b0);
    apb_write("commit4", 12'h0A4, 32'h1, 1'b0);
    chk("commit4_valid", 32'(req_valid), 32'd1);
    chk("commit4_op", 32'(req.op), 32'(TUE_MODIFY));
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(req_valid), 32'd0);
    chk("async_rst_req", 32'(|req), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    apb_read("post_rst_status", 12'h0A0, 32'h0, 1'b0);
    apb_read("post_rst_cmd", 12'h000, 32'h0, 1'b0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
